fifo_level: RTL and testbench
=============================

// Module: fifo_level
// PURPOSE
//  Synchronous single-clock FIFO that extends the basic FIFO with the following:
//  - a true fill level and programmable almost-full/almost-empty thresholds;
//  - protection against writes when full and reads when empty, with sticky error flags;
//  - a synchronous flush input;
//  - a selectable read mode: show-ahead, or registered output with a valid strobe.
//  It sits between stream producers and consumers, e.g. pixel or command paths that need back-pressure margin.
// PARAMETERS
//  DATA_WIDTH    8   data word width in bits
//  DEPTH_WIDTH   5   log2 of storage depth; DEPTH = 2**DEPTH_WIDTH words, all usable
//  AFULL_LEVEL   DEPTH-2   almost_full asserted when level >= AFULL_LEVEL (range 1..DEPTH)
//  AEMPTY_LEVEL  2   almost_empty asserted when level <= AEMPTY_LEVEL (range 0..DEPTH-1)
//  SHOW_AHEAD    1   1: rdata presents head word combinationally; 0: rdata registered, rvalid strobe
// PORTS
//  clk           in   1             clock, rising edge
//  nrst          in   1             asynchronous active-low reset
//  clear         in   1             synchronous flush; empties FIFO, clears error flags
//  wdata         in   DATA_WIDTH    write data
//  write         in   1             write request
//  read          in   1             read request
//  rdata         out  DATA_WIDTH    read data (see BEHAVIOUR for timing)
//  rvalid        out  1             SHOW_AHEAD=0: rdata valid this cycle; SHOW_AHEAD=1: equals ~empty
//  level         out  DEPTH_WIDTH+1 number of stored words, 0..DEPTH
//  full          out  1             level == DEPTH
//  empty         out  1             level == 0
//  almost_full   out  1             level >= AFULL_LEVEL
//  almost_empty  out  1             level <= AEMPTY_LEVEL
//  overflow      out  1             sticky: a write was rejected
//  underflow     out  1             sticky: a read was rejected
// BEHAVIOUR
//  Reset (nrst=0, async)
//  - Pointers and level go to 0.
//  - Outputs: empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rvalid=0, rdata=0.
//  Storage and pointers
//  - Storage is not reset.
//  - wptr and rptr are DEPTH_WIDTH bits wide and wrap modulo DEPTH.
//  - level is a separate counter: +1 on an accepted write, -1 on an accepted read, unchanged when both are accepted.
//  Accept rules, evaluated on current registered state
//  - rd_ok = read & ~empty.
//  - wr_ok = write & (~full | rd_ok).
//  - Simultaneous read and write when full: both are accepted, level stays DEPTH.
//  - Simultaneous read and write when empty: only the write is accepted; underflow is set.
//  Error flags
//  - Rejected write: memory and pointers untouched, overflow <= 1.
//  - Rejected read: pointers untouched, underflow <= 1.
//  - Both flags hold until clear or reset.
//  Flag timing
//  - full, empty, almost_* are registered from the next-state level.
//  - They are therefore exact in the cycle after the edge that changed level; there is no extra lag.
//  clear
//  - clear=1 at an edge: pointers and level go to 0, all flags return to reset values, rvalid goes to 0.
//  - read and write are ignored that cycle; clear has priority over both.
//  SHOW_AHEAD=1
//  - rdata = mem[rptr] combinationally; it is valid whenever empty=0.
//  - read acknowledges (pops) the presented word.
//  SHOW_AHEAD=0
//  - An accepted read at edge N loads rdata with mem[rptr] and sets rvalid=1 for one cycle (latency 1).
//  - rdata holds its value after that; rvalid=0 when no read is accepted.
//  Write-to-read path
//  - A word written at edge N is readable (empty=0) after edge N.
//  - Show-ahead mode: no write-through while empty; rdata is undefined while empty=1.
//  Thresholds are static parameters; the level comparisons use DEPTH_WIDTH+1-bit unsigned arithmetic.
// TESTING (DATA_WIDTH=8, DEPTH_WIDTH=2, AFULL_LEVEL=3, AEMPTY_LEVEL=1)
//  1. Reset, then 4 writes 0x11..0x44 -> level 1,2,3,4; almost_empty drops at level 2; almost_full rises at 3; full at 4; overflow=0.
//  2. Fifth write 0x55 while full -> level 4, overflow=1 sticky, then 4 reads -> 0x11,0x22,0x33,0x44 (0x55 absent), empty=1.
//  3. Read when empty -> underflow=1, level 0; then clear=1 one cycle -> overflow=underflow=0, empty=1.
//  4. Full FIFO, read+write 0x66 same cycle -> both accepted, level 4, head advances; drain ends with 0x66; repeat 10x for pointer wrap.
//  5. Empty FIFO, read+write 0x77 same cycle -> write accepted, underflow=1, level 1, next read returns 0x77.
//  6. SHOW_AHEAD=0: write 0xA5, read at edge N -> rvalid=1 and rdata=0xA5 in cycle after N only; nrst pulse mid-burst -> all outputs to reset values.

Source files
------------

// File: rtl/fifo_level.sv
// fifo_level: single-clock FIFO with a true fill level, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags, a synchronous flush and a
// selectable read mode (show-ahead or registered output with a valid strobe).
//
// Handshake semantics: write/read are requests sampled at the rising edge.
// A read is accepted when the FIFO is not empty. A write is accepted when the
// FIFO is not full, or when a read is accepted in the same cycle. A rejected
// request has no effect on storage or pointers; it only sets its sticky error
// flag. clear overrides both requests in the cycle it is high.
module fifo_level #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH_WIDTH  = 5,
    parameter int AFULL_LEVEL  = (1 << DEPTH_WIDTH) - 2,
    parameter int AEMPTY_LEVEL = 2,
    parameter int SHOW_AHEAD   = 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  write,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic [DEPTH_WIDTH:0]  level,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam int LW    = DEPTH_WIDTH + 1;

    // Level thresholds in the same width as the level counter.
    localparam logic [DEPTH_WIDTH:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [DEPTH_WIDTH:0] AFULL_L  = LW'(AFULL_LEVEL);
    localparam logic [DEPTH_WIDTH:0] AEMPTY_L = LW'(AEMPTY_LEVEL);

    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic [DEPTH_WIDTH-1:0] wptr_q, wptr_d;
    logic [DEPTH_WIDTH-1:0] rptr_q, rptr_d;
    logic [DEPTH_WIDTH:0]   level_q, level_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic                   afull_q, afull_d;
    logic                   aempty_q, aempty_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;

    logic                   rd_ok;
    logic                   wr_ok;
    logic                   mem_we;

    // Accept decisions are taken on registered state only.
    assign rd_ok  = read & ~empty_q;
    assign wr_ok  = write & (~full_q | rd_ok);
    assign mem_we = wr_ok & ~clear;

    // Next-state for pointers, level, status flags and sticky errors.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (wr_ok) wptr_d = wptr_q + DEPTH_WIDTH'(1);
            if (rd_ok) rptr_d = rptr_q + DEPTH_WIDTH'(1);
            level_d = level_q + LW'(wr_ok) - LW'(rd_ok);
            if (write & ~wr_ok) ovf_d = 1'b1;
            if (read & ~rd_ok)  unf_d = 1'b1;
        end

        // Flags come from the next level so they are exact right after the edge.
        full_d   = (level_d == DEPTH_L);
        empty_d  = (level_d == '0);
        afull_d  = (level_d >= AFULL_L);
        aempty_d = (level_d <= AEMPTY_L);
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wptr_q] <= wdata;
    end

    generate
        if (SHOW_AHEAD != 0) begin : g_show_ahead
            // Head word presented combinationally; forced to zero while empty
            // so the port never shows stale storage after reset or flush.
            assign rdata  = empty_q ? '0 : mem[rptr_q];
            assign rvalid = ~empty_q;
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
            logic                  rvalid_q, rvalid_d;

            // Registered read port: load on an accepted read, hold otherwise.
            always_comb begin
                rdata_d  = rdata_q;
                rvalid_d = 1'b0;
                if (!clear && rd_ok) begin
                    rdata_d  = mem[rptr_q];
                    rvalid_d = 1'b1;
                end
            end

            // Read data and valid strobe registers.
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign rdata  = rdata_q;
            assign rvalid = rvalid_q;
        end
    endgenerate

    assign level        = level_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_level.sv
// Bench for fifo_level: one show-ahead and one registered-read instance share
// the same stimulus and are checked every cycle against a queue-based model.
module tb_fifo_level;

    localparam int DW     = 8;
    localparam int AW     = 2;
    localparam int DEPTH  = 4;
    localparam int AFULL  = 3;
    localparam int AEMPTY = 1;

    logic          clk   = 1'b0;
    logic          nrst  = 1'b0;
    logic          clear = 1'b0;
    logic          write = 1'b0;
    logic          read  = 1'b0;
    logic [DW-1:0] wdata = '0;

    logic [DW-1:0] sa_rdata, rg_rdata;
    logic          sa_rvalid, rg_rvalid;
    logic [AW:0]   sa_level, rg_level;
    logic          sa_full, rg_full, sa_empty, rg_empty;
    logic          sa_afull, rg_afull, sa_aempty, rg_aempty;
    logic          sa_ovf, rg_ovf, sa_unf, rg_unf;

    int n_cmp  = 0;
    int n_fail = 0;

    fifo_level #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .AFULL_LEVEL(AFULL),
                 .AEMPTY_LEVEL(AEMPTY), .SHOW_AHEAD(1)) u_sa (
        .clk(clk), .nrst(nrst), .clear(clear), .wdata(wdata), .write(write),
        .read(read), .rdata(sa_rdata), .rvalid(sa_rvalid), .level(sa_level),
        .full(sa_full), .empty(sa_empty), .almost_full(sa_afull),
        .almost_empty(sa_aempty), .overflow(sa_ovf), .underflow(sa_unf)
    );

    fifo_level #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .AFULL_LEVEL(AFULL),
                 .AEMPTY_LEVEL(AEMPTY), .SHOW_AHEAD(0)) u_rg (
        .clk(clk), .nrst(nrst), .clear(clear), .wdata(wdata), .write(write),
        .read(read), .rdata(rg_rdata), .rvalid(rg_rvalid), .level(rg_level),
        .full(rg_full), .empty(rg_empty), .almost_full(rg_afull),
        .almost_empty(rg_aempty), .overflow(rg_ovf), .underflow(rg_unf)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [DW-1:0] exp_q[$];
    bit            m_ovf, m_unf, m_rv, m_rd, m_wr;
    logic [DW-1:0] m_rdata = '0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            exp_q.delete();
            m_ovf   = 0;
            m_unf   = 0;
            m_rv    = 0;
            m_rdata = '0;
        end else if (clear) begin
            exp_q.delete();
            m_ovf = 0;
            m_unf = 0;
            m_rv  = 0;
        end else begin
            m_rd = read && (exp_q.size() != 0);
            m_wr = write && ((exp_q.size() < DEPTH) || m_rd);
            if (read && !m_rd)  m_unf = 1;
            if (write && !m_wr) m_ovf = 1;
            m_rv = m_rd;
            if (m_rd) m_rdata = exp_q.pop_front();
            if (m_wr) exp_q.push_back(wdata);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    int n_m;
    always @(negedge clk) begin
        if (nrst) begin
            n_m = exp_q.size();
            check("sa_level",  32'(sa_level),  32'(n_m));
            check("rg_level",  32'(rg_level),  32'(n_m));
            check("sa_full",   32'(sa_full),   32'(n_m == DEPTH));
            check("rg_full",   32'(rg_full),   32'(n_m == DEPTH));
            check("sa_empty",  32'(sa_empty),  32'(n_m == 0));
            check("rg_empty",  32'(rg_empty),  32'(n_m == 0));
            check("sa_afull",  32'(sa_afull),  32'(n_m >= AFULL));
            check("rg_afull",  32'(rg_afull),  32'(n_m >= AFULL));
            check("sa_aempty", 32'(sa_aempty), 32'(n_m <= AEMPTY));
            check("rg_aempty", 32'(rg_aempty), 32'(n_m <= AEMPTY));
            check("sa_ovf",    32'(sa_ovf),    32'(m_ovf));
            check("rg_ovf",    32'(rg_ovf),    32'(m_ovf));
            check("sa_unf",    32'(sa_unf),    32'(m_unf));
            check("rg_unf",    32'(rg_unf),    32'(m_unf));
            check("sa_rvalid", 32'(sa_rvalid), 32'(n_m != 0));
            if (n_m != 0) check("sa_rdata", 32'(sa_rdata), 32'(exp_q[0]));
            check("rg_rvalid", 32'(rg_rvalid), 32'(m_rv));
            check("rg_rdata",  32'(rg_rdata),  32'(m_rdata));
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        write = w;
        wdata = d;
        read  = r;
        clear = c;
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_level"},  32'(sa_level),  0);
        check({tag, "_empty"},  32'(sa_empty),  1);
        check({tag, "_aempty"}, 32'(rg_aempty), 1);
        check({tag, "_full"},   32'(rg_full),   0);
        check({tag, "_afull"},  32'(sa_afull),  0);
        check({tag, "_ovf"},    32'(rg_ovf),    0);
        check({tag, "_unf"},    32'(sa_unf),    0);
        check({tag, "_rvalid"}, 32'(rg_rvalid), 0);
        check({tag, "_rdata"},  32'(rg_rdata),  0);
        check({tag, "_sa_rv"},  32'(sa_rvalid), 0);
    endtask

    // ---------------- main sequence ----------------
    logic [DW-1:0] exp_pop;
    int            wp, rp, ph;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk);
        nrst = 1'b1;

        // 1: fill to full
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
            check("t1_level", 32'(sa_level), 32'(i + 1));
        end
        check("t1_full", 32'(rg_full), 1);
        check("t1_afull", 32'(sa_afull), 1);
        check("t1_aempty", 32'(sa_aempty), 0);
        check("t1_ovf", 32'(sa_ovf), 0);
        check("t1_head", 32'(sa_rdata), 32'h11);

        // 2: overflow then drain
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        check("t2_level", 32'(rg_level), 4);
        check("t2_ovf", 32'(rg_ovf), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            check("t2_rdata", 32'(rg_rdata), 32'(8'h11 * (i + 1)));
            check("t2_rvalid", 32'(rg_rvalid), 1);
        end
        check("t2_empty", 32'(sa_empty), 1);
        check("t2_ovf_sticky", 32'(sa_ovf), 1);

        // 3: underflow, then clear
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t3_unf", 32'(rg_unf), 1);
        check("t3_level", 32'(rg_level), 0);
        cyc(1'b1, 8'hEE, 1'b1, 1'b1);
        check("t3_clr_ovf", 32'(sa_ovf), 0);
        check("t3_clr_unf", 32'(rg_unf), 0);
        check("t3_clr_empty", 32'(rg_empty), 1);

        // 4: read+write while full, with pointer wrap
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(i + 1), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
            exp_pop = (i < 4) ? 8'(i + 1) : 8'(8'h60 + i - 4);
            check("t4_level", 32'(sa_level), 4);
            check("t4_pop", 32'(rg_rdata), 32'(exp_pop));
        end
        check("t4_ovf", 32'(rg_ovf), 0);
        for (int j = 0; j < 4; j++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            check("t4_drain", 32'(rg_rdata), 32'(8'h66 + j));
        end

        // 5: read+write while empty
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        check("t5_unf", 32'(sa_unf), 1);
        check("t5_level", 32'(rg_level), 1);
        check("t5_rvalid", 32'(rg_rvalid), 0);
        check("t5_head", 32'(sa_rdata), 32'h77);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t5_rdata", 32'(rg_rdata), 32'h77);
        check("t5_rv", 32'(rg_rvalid), 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // 6: registered read latency, then reset mid-burst
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        check("t6_rv_pre", 32'(rg_rvalid), 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t6_rv", 32'(rg_rvalid), 1);
        check("t6_rdata", 32'(rg_rdata), 32'hA5);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("t6_rv_drop", 32'(rg_rvalid), 0);
        check("t6_rdata_hold", 32'(rg_rdata), 32'hA5);
        cyc(1'b1, 8'h01, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0);
        write = 1'b1;
        wdata = 8'h03;
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check_reset_values("t6_rst");
        @(posedge clk);
        #1;
        write = 1'b0;
        @(negedge clk);
        nrst = 1'b1;

        // random traffic with phases biased towards fill, drain and balance
        for (int c = 0; c < 3000; c++) begin
            ph = (c / 150) % 3;
            wp = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
            rp = (ph == 0) ? 25 : (ph == 1) ? 80 : 50;
            write = ($urandom_range(0, 99) < wp);
            read  = ($urandom_range(0, 99) < rp);
            clear = ($urandom_range(0, 199) == 0);
            wdata = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
        write = 1'b0;
        read  = 1'b0;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
